// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer: up to FETCH_WIDTH entries pushed per cycle,
// one popped per cycle, single-cycle flush that drops every held entry.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int BUF_DEPTH   = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               push_i,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]   push_cnt_i,
  input  fetch_entry_t [FETCH_WIDTH-1:0]     push_data_i,
  input  logic                               pop_i,
  output logic                               valid_o,
  output fetch_entry_t                       head_o,
  output logic [$clog2(BUF_DEPTH):0]         count_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(FETCH_WIDTH + 1);

  fetch_entry_t   mem_q [BUF_DEPTH];
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_pop_s;

  assign valid_o  = (count_q != {CW{1'b0}});
  assign do_pop_s = pop_i & valid_o;
  assign head_o   = mem_q[head_q];
  assign count_o  = count_q;

  // Pointer and occupancy next state; flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = {CW{1'b0}};
    end else begin
      if (push_i) begin
        tail_d  = tail_q + AW'(push_cnt_i);
        count_d = count_q + CW'(push_cnt_i);
      end else begin
        tail_d  = tail_q;
        count_d = count_q;
      end
      if (do_pop_s) begin
        head_d  = head_q + AW'(1);
        count_d = count_d - CW'(1);
      end else begin
        head_d  = head_q;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; a group may wrap past the last slot.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (PW'(k) < push_cnt_i) begin
          mem_q[tail_q + AW'(k)] <= push_data_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: PC generation, credit-based memory requests and a
// buffered valid/ready output. Optional FETCH_HALT_ON_ZERO_EN stops on 32'h0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              FETCH_WIDTH = 2,
  parameter int              BUF_DEPTH   = 8,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_req,
  output logic [XLEN-1:0]                imem_addr,
  input  logic [INSTR_W*FETCH_WIDTH-1:0] imem_rdata,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INSTR_W-1:0]             out_instr,
  output logic [XLEN-1:0]                out_pc,
  output logic                           stop_out
);

  localparam int              CW          = $clog2(BUF_DEPTH) + 1;
  localparam int              PW          = $clog2(FETCH_WIDTH + 1);
  localparam logic [XLEN-1:0] GROUP_BYTES = XLEN'(4 * FETCH_WIDTH);

  logic [XLEN-1:0]              pc_q, pc_d;
  logic [XLEN-1:0]              req_pc_q, req_pc_d;
  logic                         inflight_q, inflight_d;
  logic                         halted_q, halted_d;
  logic [31:0]                  need_s;
  logic                         credit_s;
  logic [CW-1:0]                count_s;
  logic                         buf_valid_s;
  fetch_entry_t                 head_s;
  logic                         push_s;
  logic [PW-1:0]                push_cnt_s;
  fetch_entry_t [FETCH_WIDTH-1:0] push_data_s;

  // Room must remain for the group already in flight plus the new one.
  assign need_s   = 32'(count_s) + (inflight_q ? 32'(FETCH_WIDTH) : 32'd0) + 32'(FETCH_WIDTH);
  assign credit_s = (need_s <= 32'(BUF_DEPTH));
  assign imem_req  = ~rst & ~halted_q & ~redirect_valid & credit_s;
  assign imem_addr = pc_q;

  assign push_s = inflight_q & ~redirect_valid & ~halted_q;

  // Split the returned group into buffer entries tagged with their PCs.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      push_data_s[k].instr = imem_rdata[INSTR_W*k +: INSTR_W];
      push_data_s[k].pc    = req_pc_q + XLEN'(4 * k);
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  logic zero_hit_s;
  logic stop_q;

  // Truncate the group at its first all-zero word.
  always_comb begin
    push_cnt_s = PW'(FETCH_WIDTH);
    zero_hit_s = 1'b0;
    for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
      if (imem_rdata[INSTR_W*k +: INSTR_W] == 32'h0000_0000) begin
        push_cnt_s = PW'(k);
        zero_hit_s = 1'b1;
      end else begin
        zero_hit_s = zero_hit_s;
      end
    end
  end

  assign stop_out = stop_q | (halted_q & ~buf_valid_s);

  // Sticky program-end flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_out;
    end
  end
`else
  assign push_cnt_s = PW'(FETCH_WIDTH);
  assign stop_out   = 1'b0;
`endif

  // PC, in-flight tracking and halt next state; redirect has top priority.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    halted_d   = halted_q;
    if (redirect_valid) begin
      pc_d     = align_pc(redirect_pc);
      halted_d = halted_q & stop_out;
    end else begin
      if (imem_req) begin
        pc_d     = pc_q + GROUP_BYTES;
        req_pc_d = pc_q;
      end else begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
      end
`ifdef FETCH_HALT_ON_ZERO_EN
      if (push_s && zero_hit_s) begin
        halted_d = 1'b1;
      end else begin
        halted_d = halted_q;
      end
`endif
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  fetch_buffer #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .BUF_DEPTH   (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (push_s),
    .push_cnt_i  (push_cnt_s),
    .push_data_i (push_data_s),
    .pop_i       (out_ready),
    .valid_o     (buf_valid_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  assign out_valid = buf_valid_s;
  assign out_instr = buf_valid_s ? head_s.instr : {INSTR_W{1'b0}};
  assign out_pc    = buf_valid_s ? head_s.pc    : {XLEN{1'b0}};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing sequences, a redirect
// vector table and a randomized phase checked against a queue-based model.
module tb_fetch_unit;

  localparam int          FW    = 2;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic [32*FW-1:0]  imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              stop_out;

  fetch_unit #(.FETCH_WIDTH(FW), .BUF_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .stop_out(stop_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory content: a scrambled function of the address, zero only at zero_addr.
  logic [31:0] zero_addr = 32'hFFFF_FFFF;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == zero_addr) ? 32'h0000_0000 : (a ^ 32'h5A00_0001);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < FW; k++) begin
      if (imem_req) imem_rdata[32*k +: 32] <= word(imem_addr + 32'(4*k));
      else          imem_rdata[32*k +: 32] <= $urandom;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  ent_t        ne;
  bit          model_on = 1'b0;
  bit          m_inflight = 1'b0, m_halted = 1'b0, m_stop = 1'b0;
  logic [31:0] m_pc = RPC, m_ipc = RPC;
  bit          e_valid, e_req, e_stop, hs, cut;
  logic [31:0] e_pc, e_instr, w;
  int          sz;

  always @(negedge clk) begin
    if (model_on) begin
      sz      = mq.size();
      e_valid = (sz != 0);
      e_pc    = e_valid ? mq[0].pc : 32'h0;
      e_instr = e_valid ? mq[0].instr : 32'h0;
      e_req   = !rst && !m_halted && !redirect_valid && (DEPTH - sz - (m_inflight ? FW : 0) >= FW);
`ifdef FETCH_HALT_ON_ZERO_EN
      e_stop  = m_stop || (m_halted && sz == 0);
`else
      e_stop  = 1'b0;
`endif
      check("m_req",   32'(imem_req),  32'(e_req));
      check("m_addr",  imem_addr,      m_pc);
      check("m_valid", 32'(out_valid), 32'(e_valid));
      check("m_pc",    out_pc,         e_pc);
      check("m_instr", out_instr,      e_instr);
      check("m_stop",  32'(stop_out),  32'(e_stop));
      hs = e_valid && out_ready;
      if (rst) begin
        mq.delete(); m_inflight = 0; m_pc = RPC; m_halted = 0; m_stop = 0;
      end else if (redirect_valid) begin
        mq.delete(); m_inflight = 0; m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_halted = m_halted && e_stop; m_stop = e_stop;
      end else begin
        m_stop = e_stop;
        if (hs) void'(mq.pop_front());
        if (m_inflight && !m_halted) begin
          cut = 1'b0;
          for (int k = 0; k < FW; k++) begin
            w = word(m_ipc + 32'(4*k));
`ifdef FETCH_HALT_ON_ZERO_EN
            if (w == 32'h0) cut = 1'b1;
`endif
            if (!cut) begin
              ne.instr = w; ne.pc = m_ipc + 32'(4*k);
              mq.push_back(ne);
            end
          end
          if (cut) m_halted = 1'b1;
        end
        m_inflight = e_req;
        if (e_req) begin m_ipc = m_pc; m_pc = m_pc + 32'(4*FW); end
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  typedef struct {
    logic [31:0] tgt;
    int          stall;
    logic [31:0] exp0;
    logic [31:0] exp2;
  } rd_vec_t;
  rd_vec_t rv[4];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int ndel;

  initial begin
    rv[0] = '{32'h0000_0100, 3, 32'h0000_0100, 32'h0000_0108};
    rv[1] = '{32'h0000_0203, 0, 32'h0000_0200, 32'h0000_0208};
    rv[2] = '{32'hFFFF_FFFA, 5, 32'hFFFF_FFF8, 32'h0000_0000};
    rv[3] = '{32'h0000_1006, 2, 32'h0000_1004, 32'h0000_100C};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    tick();
    model_on = 1'b1;
    tick();
    @(negedge clk);
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_addr",  imem_addr,      RPC);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr,      32'd0);
    check("rst_pc",    out_pc,         32'd0);
    check("rst_stop",  32'(stop_out),  32'd0);

    // Startup and steady-state streaming.
    tick(); rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("start_req0",  32'(imem_req), 32'd1);
        check("start_addr0", imem_addr,     32'h0);
      end
      if (c == 1) begin
        check("start_valid1", 32'(out_valid), 32'd0);
        check("start_addr1",  imem_addr,      32'h8);
      end
      if (c >= 2) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_pc",    out_pc,         32'(4*(c-2)));
      end
      tick();
    end

    // Backpressure.
    out_ready = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check("bp_req",   32'(imem_req),      32'd0);
    check("bp_count", 32'(dut.count_s),   32'd8);
    check("bp_pc",    out_pc,             32'h70);
    tick(); out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("bp_rel_valid", 32'(out_valid), 32'd1);
      check("bp_rel_pc",    out_pc,         32'h70 + 32'(4*i));
      tick();
    end

    // Redirect vector table.
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      repeat (rv[i].stall) tick();
      redirect_valid = 1'b1; redirect_pc = rv[i].tgt; out_ready = 1'b1;
      @(negedge clk);
      check("rd_req_t0", 32'(imem_req), 32'd0);
      tick(); redirect_valid = 1'b0;
      @(negedge clk);
      check("rd_req_t1",   32'(imem_req),  32'd1);
      check("rd_addr_t1",  imem_addr,      rv[i].exp0);
      check("rd_valid_t1", 32'(out_valid), 32'd0);
      tick(); @(negedge clk);
      check("rd_valid_t2", 32'(out_valid), 32'd0);
      tick(); @(negedge clk);
      check("rd_valid_t3", 32'(out_valid), 32'd1);
      check("rd_pc_t3",    out_pc,         rv[i].exp0);
      tick(); @(negedge clk);
      check("rd_pc_t4",    out_pc,         rv[i].exp0 + 32'd4);
      tick(); @(negedge clk);
      check("rd_pc_t5",    out_pc,         rv[i].exp2);
      repeat (3) tick();
    end

    // Reset mid-operation.
    out_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk);
    check("mrst_req", 32'(imem_req), 32'd0);
    tick(); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_instr", out_instr,      32'd0);
    check("mrst_pc",    out_pc,         32'd0);
    check("mrst_req0",  32'(imem_req),  32'd1);
    check("mrst_addr0", imem_addr,      RPC);
    tick(); @(negedge clk);
    check("mrst_valid1", 32'(out_valid), 32'd0);
    tick(); @(negedge clk);
    check("mrst_valid2", 32'(out_valid), 32'd1);
    check("mrst_pc2",    out_pc,         RPC);
    check("mrst_instr2", out_instr,      word(RPC));
    tick();

    // Zero word at 0x24.
    rst = 1'b1; tick();
    zero_addr = 32'h0000_0024; rst = 1'b0; out_ready = 1'b1; ndel = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) ndel++;
      tick();
    end
    @(negedge clk);
`ifdef FETCH_HALT_ON_ZERO_EN
    check("halt_ndel",  32'(ndel),      32'd9);
    check("halt_req",   32'(imem_req),  32'd0);
    check("halt_stop",  32'(stop_out),  32'd1);
    check("halt_valid", 32'(out_valid), 32'd0);
`else
    check("zero_ndel", 32'(ndel),     32'd38);
    check("zero_stop", 32'(stop_out), 32'd0);
`endif
    tick(); rst = 1'b1; zero_addr = 32'hFFFF_FFFF;
    tick(); rst = 1'b0;

    // Random phase.
    for (int c = 0; c < 1500; c++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised front-end fetch stage that replaces the free-running PC counter feeding `IF_ID_Reg`. It generates a PC and issues multi-word fetch requests to a one-cycle-latency instruction memory. Returned words are held in a circular instruction buffer and handed to decode one per cycle under a valid/ready handshake. It supports backpressure from decode/rename stalls and PC redirects from branch resolution.

## Interface
Parameters:
- `FETCH_WIDTH`, 2: instructions fetched per request. Legal values are 1, 2 or 4.
- `BUF_DEPTH`, 8: instruction buffer entries. Must be a power of 2 and ≥ 2·`FETCH_WIDTH`.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.

Ports:
- `clk`  in  1  clock. Every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request issued this cycle.
- `imem_addr`  out  32  byte address of the first word of the group. Word k is at `imem_addr`+4k.
- `imem_rdata`  in  32·`FETCH_WIDTH`  group returned in the cycle after `imem_req`. Word k is in bits [32k+31:32k].
- `redirect_valid`  in  1  flush the unit and restart fetch.
- `redirect_pc`  in  32  new PC. Bits [1:0] are ignored and treated as 0.
- `out_valid`  out  1  the buffer head holds an instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  PC of the head instruction.
- `stop_out`  out  1  program end reached and buffer drained. Sticky until `rst`.

## Operation
- State:
  - `pc`
  - `inflight` (1 bit: a request was issued last cycle)
  - buffer `head`/`tail` pointers and `count` (log2(`BUF_DEPTH`)+1 bits)
  - `halted`
- Credit rule: `imem_req` = !`rst` & !`halted` & !`redirect_valid` & (`BUF_DEPTH` − `count` − `inflight`·`FETCH_WIDTH` ≥ `FETCH_WIDTH`).
  - `imem_addr` = `pc` at all times.
  - On a request, `pc` advances by 4·`FETCH_WIDTH` (mod 2^32).
- Response handling: when `inflight`=1, all `FETCH_WIDTH` words are enqueued at `tail` in order.
  - Each entry stores its instruction and its PC (request PC + 4k).
  - The credit rule guarantees space, so overflow is impossible. Verification asserts `count` ≤ `BUF_DEPTH`.
- Dequeue: when `out_valid` & `out_ready`, `head` advances by 1.
  - Enqueue and dequeue in the same cycle are both applied: `count` += `FETCH_WIDTH` − 1.
- Pointer wrap: `head` and `tail` wrap modulo `BUF_DEPTH`. A group may straddle the wrap point.
- Redirect takes priority over every other event in the same cycle:
  - buffer emptied (`count`←0, `head`←`tail`)
  - any response arriving this cycle is discarded
  - `inflight`←0, `pc`←{`redirect_pc`[31:2],2'b0}
  - `halted`←0 unless `stop_out` is set
  - any dequeue handshake in this cycle is ignored by the producer side
- Reset mid-operation: every register returns to its reset value on the next edge. A response returning after reset is discarded because `inflight` resets to 0.

## Timing
- Reset values:
  - `imem_req`=0 (while `rst`=1)
  - `imem_addr`=`RESET_PC`
  - `out_valid`=0, `out_instr`=0, `out_pc`=0
  - `stop_out`=0
- Outputs are combinational from registered state only. There is no combinational path from `out_ready` or `redirect_valid` to `out_*`.
- Startup: first cycle with `rst`=0 is cycle 0. `imem_req`=1 at cycle 0, data is enqueued at the end of cycle 1, and `out_valid`=1 from cycle 2.
- Redirect latency: `redirect_valid` at cycle t gives `imem_req` with `redirect_pc` at t+1 and `out_valid` at t+3.
- Steady state with `out_ready` held high: one instruction is delivered per cycle with no bubbles.

## Configuration
- `FETCH_HALT_ON_ZERO_EN` defined:
  - A word equal to 32'h0 in a response is not enqueued. Later words of that group are discarded too.
  - `halted`←1, which stops further requests.
  - `stop_out` rises in the first cycle with `halted`=1 and `count`=0, and stays high until `rst`.
- Not defined: 32'h0 is enqueued like any other word, `halted` is never set, and `stop_out` is tied to 0.

## Structure
- Shared package `fetch_pkg` holds:
  - `XLEN`=32, `INSTR_W`=32
  - `NOP_INSTR`=32'h0000_0013
  - typedef `fetch_entry_t` {instr, pc}
- Sub-module `fetch_buffer`: circular FIFO with a multi-word enqueue port (`FETCH_WIDTH` words per push), single-word dequeue, and flush. It owns `head`, `tail` and `count`.
- Top-level `fetch_unit` owns `pc`, `inflight`, `halted`, and the credit and redirect logic.

## Test plan
- Startup, `FETCH_WIDTH`=2, `RESET_PC`=0, `out_ready`=1, memory word at address a = a: `out_pc`/`out_instr` sequence is 0,4,8,… starting at cycle 2, one per cycle, with no gaps.
- Backpressure, `out_ready`=0 for 20 cycles: `count` saturates at 8, `imem_req` falls to 0, and no entry is lost. On release, `out_pc` continues contiguously.
- Redirect to 0x100 while the buffer holds 5 entries and a response is in flight: the next `out_pc` is 0x100 at t+3, and no stale PC appears.
- `BUF_DEPTH`=8, `FETCH_WIDTH`=4: groups straddle the pointer wrap, and 1000 sequential instructions arrive in order.
- With `FETCH_HALT_ON_ZERO_EN`, 32'h0 at 0x24: instructions 0x0–0x20 are delivered, `imem_req` stays 0, and `stop_out`=1 once drained.
- Assert `rst` while 6 entries are buffered and a request is in flight: the next cycle shows every output at its reset value, and fetch restarts at `RESET_PC`.
